parity_stream_chk: RTL

Parametrised streaming parity checker: accepts DATA_W+1-bit words (payload plus parity bit in the MSB) over a valid/ready handshake and checks each against a runtime-selectable even/odd rule. It forwards the payload with a per-word error flag one cycle later, keeps saturating word and error counters, and raises a sticky alarm after a run of consecutive bad words. It sits between a serial/byte deserialiser and downstream consumers, replacing the fixed 9-bit even/odd parity detector.

---
 rtl/parity_pkg.sv | 20 ++
 rtl/parity_calc.sv | 15 +
 rtl/parity_stream_chk.sv | 112 +++++++++++
 3 files changed

// File: rtl/parity_pkg.sv
// Shared types and helpers for the streaming parity checker family.
package parity_pkg;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } mode_t;

  typedef enum logic [1:0] {
    OK      = 2'd0,
    SUSPECT = 2'd1,
    ALARM   = 2'd2
  } burst_state_t;

  // Bits needed to count 0..lim consecutive bad words.
  function automatic int burst_w(input int lim);
    return $clog2(lim + 1);
  endfunction

endpackage

// File: rtl/parity_calc.sv
// Combinational parity check: reduction XOR of the whole word, inverted for odd mode.
module parity_calc
  import parity_pkg::*;
#(
  parameter int W = 9
) (
  input  logic [W-1:0] word,
  input  logic         mode,
  output logic         err
);

  // Even: a set reduction XOR is an error. Odd: a clear one is.
  assign err = (^word) ^ (mode_t'(mode) == ODD);

endmodule

// File: rtl/parity_stream_chk.sv
// Streaming parity checker: one-deep output register, saturating counters and burst alarm FSM.
module parity_stream_chk
  import parity_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 16,
  parameter int BURST_LIM = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  input  logic              clr,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              alarm
);

  localparam int BW = burst_w(BURST_LIM);

  logic          accept;
  logic          err;
  burst_state_t  state, state_nxt, state_base;
  logic [BW-1:0] burst, burst_nxt, burst_base, burst_inc;

  parity_calc #(.W(DATA_W + 1)) u_calc (
    .word (in_data),
    .mode (mode),
    .err  (err)
  );

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign alarm    = (state == ALARM);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data[DATA_W-1:0];
      out_err   <= err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // clr restarts counting from zero but still counts a word accepted in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt <= '0;
      err_cnt  <= '0;
    end else if (clr) begin
      word_cnt <= accept ? CNT_W'(1) : '0;
      err_cnt  <= (accept && err) ? CNT_W'(1) : '0;
    end else if (accept) begin
      if (word_cnt != '1) word_cnt <= word_cnt + CNT_W'(1);
      if (err && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= OK;
      burst <= '0;
    end else begin
      state <= state_nxt;
      burst <= burst_nxt;
    end
  end

  always_comb begin
    state_base = clr ? OK : state;
    burst_base = clr ? '0 : burst;
    burst_inc  = burst_base + BW'(1);
    state_nxt  = state_base;
    burst_nxt  = burst_base;
    if (accept) begin
      case (state_base)
        OK: begin
          if (err) begin
            burst_nxt = BW'(1);
            state_nxt = (BURST_LIM == 1) ? ALARM : SUSPECT;
          end
        end
        SUSPECT: begin
          if (err) begin
            burst_nxt = burst_inc;
            if (burst_inc == BW'(BURST_LIM)) state_nxt = ALARM;
          end else begin
            burst_nxt = '0;
            state_nxt = OK;
          end
        end
        ALARM: state_nxt = ALARM;
        default: begin
          state_nxt = OK;
          burst_nxt = '0;
        end
      endcase
    end
  end

endmodule
